eth_rx_errcnt: RTL and testbench

ETH_RX_ERRCNT -- requirements
Module: eth_rx_errcnt

---
 rtl/eth_rx_errcnt.sv | 123 ++++++++++++
 tb/tb_eth_rx_errcnt.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/eth_rx_errcnt.sv
// Per-port Ethernet RX error counters (CRC / length), sticky error flags and activity timers.
// Optional snapshot of the counter outputs is enabled by defining ETH_ERRCNT_SNAP_EN.
module eth_rx_errcnt #(
  parameter int unsigned ACT_TIMEOUT = 125000000
) (
  input  logic        s_axi_clk,
  input  logic        s_axi_rst,
  input  logic [3:0]  rx_eof,
  input  logic [3:0]  rx_crc_err,
  input  logic [3:0]  rx_len_err,
  input  logic        cnt_clr,
  input  logic        snap_req,
  output logic [31:0] cnterr_eth0,
  output logic [31:0] cnterr_eth1,
  output logic [31:0] cnterr_eth2,
  output logic [31:0] cnterr_eth3,
  output logic [31:0] status_eth
);

  localparam int unsigned NPORT = 4;
  localparam int unsigned CW    = 16;
  localparam int unsigned TW    = 32;
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [TW-1:0] TMR_LOAD = TW'(ACT_TIMEOUT);

  logic [NPORT-1:0][CW-1:0] crc_cnt_q, crc_cnt_d;
  logic [NPORT-1:0][CW-1:0] len_cnt_q, len_cnt_d;
  logic [NPORT-1:0]         crc_stk_q, crc_stk_d;
  logic [NPORT-1:0]         len_stk_q, len_stk_d;
  logic [NPORT-1:0][TW-1:0] tmr_q, tmr_d;
  logic                     cnt_clr_q, cnt_clr_d;

  logic             clr_ev_c;
  logic [NPORT-1:0] crc_ev_c;
  logic [NPORT-1:0] len_ev_c;
  logic [NPORT-1:0] act_c;

  // A clear and an error in the same cycle: clear the base first, then count the error.
  always_comb begin
    cnt_clr_d = cnt_clr;
    clr_ev_c  = cnt_clr & ~cnt_clr_q;
    crc_ev_c  = rx_eof & rx_crc_err;
    len_ev_c  = rx_eof & rx_len_err;
    crc_cnt_d = clr_ev_c ? '0 : crc_cnt_q;
    len_cnt_d = clr_ev_c ? '0 : len_cnt_q;
    crc_stk_d = (clr_ev_c ? '0 : crc_stk_q) | crc_ev_c;
    len_stk_d = (clr_ev_c ? '0 : len_stk_q) | len_ev_c;
    tmr_d     = tmr_q;
    act_c     = '0;
    for (int i = 0; i < int'(NPORT); i++) begin
      if (crc_ev_c[i] && (crc_cnt_d[i] != CNT_MAX)) crc_cnt_d[i] = crc_cnt_d[i] + CW'(1);
      if (len_ev_c[i] && (len_cnt_d[i] != CNT_MAX)) len_cnt_d[i] = len_cnt_d[i] + CW'(1);
      if (rx_eof[i]) begin
        tmr_d[i] = TMR_LOAD;
      end else if (tmr_q[i] != '0) begin
        tmr_d[i] = tmr_q[i] - TW'(1);
      end
      act_c[i] = (tmr_q[i] != '0);
    end
  end

  always_ff @(posedge s_axi_clk or posedge s_axi_rst) begin
    if (s_axi_rst) begin
      crc_cnt_q <= '0;
      len_cnt_q <= '0;
      crc_stk_q <= '0;
      len_stk_q <= '0;
      tmr_q     <= '0;
      cnt_clr_q <= 1'b0;
    end else begin
      crc_cnt_q <= crc_cnt_d;
      len_cnt_q <= len_cnt_d;
      crc_stk_q <= crc_stk_d;
      len_stk_q <= len_stk_d;
      tmr_q     <= tmr_d;
      cnt_clr_q <= cnt_clr_d;
    end
  end

`ifdef ETH_ERRCNT_SNAP_EN
  logic                  snap_q, snap_d;
  logic                  snap_ev_c;
  logic [NPORT-1:0][31:0] snap_val_q, snap_val_d;

  // Snapshot takes the next-state counters so same-cycle events are captured.
  always_comb begin
    snap_d     = snap_req;
    snap_ev_c  = snap_req & ~snap_q;
    snap_val_d = snap_val_q;
    if (clr_ev_c) begin
      snap_val_d = '0;
    end else if (snap_ev_c) begin
      for (int i = 0; i < int'(NPORT); i++) snap_val_d[i] = {len_cnt_d[i], crc_cnt_d[i]};
    end
  end

  always_ff @(posedge s_axi_clk or posedge s_axi_rst) begin
    if (s_axi_rst) begin
      snap_q     <= 1'b0;
      snap_val_q <= '0;
    end else begin
      snap_q     <= snap_d;
      snap_val_q <= snap_val_d;
    end
  end

  assign cnterr_eth0 = snap_val_q[0];
  assign cnterr_eth1 = snap_val_q[1];
  assign cnterr_eth2 = snap_val_q[2];
  assign cnterr_eth3 = snap_val_q[3];
`else
  logic snap_unused;
  assign snap_unused = snap_req;

  assign cnterr_eth0 = {len_cnt_q[0], crc_cnt_q[0]};
  assign cnterr_eth1 = {len_cnt_q[1], crc_cnt_q[1]};
  assign cnterr_eth2 = {len_cnt_q[2], crc_cnt_q[2]};
  assign cnterr_eth3 = {len_cnt_q[3], crc_cnt_q[3]};
`endif

  assign status_eth = {20'd0, len_stk_q, crc_stk_q, act_c};

endmodule

// File: tb/tb_eth_rx_errcnt.sv
// Directed bench for eth_rx_errcnt with ACT_TIMEOUT=16.
module tb_eth_rx_errcnt;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rx_eof, rx_crc_err, rx_len_err;
  logic        cnt_clr, snap_req;
  logic [31:0] cnterr_eth0, cnterr_eth1, cnterr_eth2, cnterr_eth3, status_eth;

  int total = 0;
  int bad   = 0;

  eth_rx_errcnt #(.ACT_TIMEOUT(16)) dut (
    .s_axi_clk  (clk),
    .s_axi_rst  (rst),
    .rx_eof     (rx_eof),
    .rx_crc_err (rx_crc_err),
    .rx_len_err (rx_len_err),
    .cnt_clr    (cnt_clr),
    .snap_req   (snap_req),
    .cnterr_eth0(cnterr_eth0),
    .cnterr_eth1(cnterr_eth1),
    .cnterr_eth2(cnterr_eth2),
    .cnterr_eth3(cnterr_eth3),
    .status_eth (status_eth)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] eof, input logic [3:0] crc, input logic [3:0] len);
    rx_eof = eof; rx_crc_err = crc; rx_len_err = len;
    tick();
    rx_eof = '0; rx_crc_err = '0; rx_len_err = '0;
  endtask

  initial begin
    rst = 1'b1;
    rx_eof = '0; rx_crc_err = '0; rx_len_err = '0;
    cnt_clr = 1'b0; snap_req = 1'b0;
    #1;
    chk("rst_eth0", cnterr_eth0, 32'h0);
    chk("rst_eth3", cnterr_eth3, 32'h0);
    chk("rst_status", status_eth, 32'h0);
    tick(); tick();
    rst = 1'b0;

`ifdef ETH_ERRCNT_SNAP_EN
    repeat (4) pulse(4'b0001, 4'b0001, 4'b0000);
    chk("snap_before", cnterr_eth0, 32'h0000_0000);
    chk("snap_status_live", status_eth, 32'h0000_0011);
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    chk("snap_first", cnterr_eth0, 32'h0000_0004);
    repeat (2) pulse(4'b0001, 4'b0001, 4'b0000);
    chk("snap_hold", cnterr_eth0, 32'h0000_0004);
    tick();
    chk("snap_hold2", cnterr_eth0, 32'h0000_0004);
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    chk("snap_second", cnterr_eth0, 32'h0000_0006);
    tick();
    snap_req = 1'b1; pulse(4'b0001, 4'b0001, 4'b0000); snap_req = 1'b0;
    chk("snap_same_cycle", cnterr_eth0, 32'h0000_0007);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("snap_clear", cnterr_eth0, 32'h0000_0000);
    chk("snap_clear_stk", status_eth & 32'hFF0, 32'h0);
`else
    // error flags without end-of-frame are ignored
    rx_crc_err = 4'hF; rx_len_err = 4'hF; tick();
    rx_crc_err = '0; rx_len_err = '0;
    chk("ignore_eth0", cnterr_eth0, 32'h0);
    chk("ignore_status", status_eth, 32'h0);

    repeat (3) pulse(4'b0010, 4'b0010, 4'b0000);
    repeat (2) pulse(4'b0010, 4'b0000, 4'b0010);
    chk("p1_eth1", cnterr_eth1, 32'h0002_0003);
    chk("p1_eth0", cnterr_eth0, 32'h0);
    chk("p1_eth2", cnterr_eth2, 32'h0);
    chk("p1_status", status_eth, 32'h0000_0222);

    pulse(4'hF, 4'hF, 4'hF);
    chk("all_eth0", cnterr_eth0, 32'h0001_0001);
    chk("all_eth1", cnterr_eth1, 32'h0003_0004);
    chk("all_eth2", cnterr_eth2, 32'h0001_0001);
    chk("all_eth3", cnterr_eth3, 32'h0001_0001);
    chk("all_status", status_eth, 32'h0000_0FFF);

    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("clr_eth1", cnterr_eth1, 32'h0);
    chk("clr_eth3", cnterr_eth3, 32'h0);
    chk("clr_status", status_eth, 32'h0000_000F);

    repeat (5) pulse(4'b0100, 4'b0100, 4'b0000);
    chk("p2_five", cnterr_eth2, 32'h0000_0005);
    cnt_clr = 1'b1;
    pulse(4'b0100, 4'b0100, 4'b0000);
    chk("clr_coinc_eth2", cnterr_eth2, 32'h0000_0001);
    chk("clr_coinc_stk", status_eth & 32'hFF0, 32'h0000_0040);
    tick(); tick();
    pulse(4'b0100, 4'b0100, 4'b0000);
    repeat (7) tick();
    chk("clr_held_eth2", cnterr_eth2, 32'h0000_0002);
    chk("clr_held_stk", status_eth & 32'hFF0, 32'h0000_0040);
    cnt_clr = 1'b0;

    rx_eof = 4'b0001; rx_crc_err = 4'b0001;
    repeat (65540) tick();
    rx_eof = '0; rx_crc_err = '0;
    chk("sat_eth0", cnterr_eth0, 32'h0000_FFFF);
    chk("sat_stk", status_eth & 32'hFF0, 32'h0000_0050);

    repeat (20) tick();
    chk("idle_act", status_eth & 32'hF, 32'h0);
    pulse(4'b1000, 4'b0000, 4'b0000);
    chk("act_c1", status_eth & 32'h8, 32'h8);
    repeat (14) tick();
    chk("act_c15", status_eth & 32'h8, 32'h8);
    tick();
    chk("act_c16", status_eth & 32'h8, 32'h8);
    tick();
    chk("act_c17", status_eth & 32'h8, 32'h0);
    chk("act_eth3", cnterr_eth3, 32'h0);

    // retrigger at cycle 10 extends the window to 25 cycles total
    repeat (5) tick();
    pulse(4'b1000, 4'b0000, 4'b0000);
    repeat (8) tick();
    pulse(4'b1000, 4'b0000, 4'b0000);
    repeat (6) tick();
    chk("ext_c16", status_eth & 32'h8, 32'h8);
    repeat (9) tick();
    chk("ext_c25", status_eth & 32'h8, 32'h8);
    tick();
    chk("ext_c26", status_eth & 32'h8, 32'h0);

    #3;
    rst = 1'b1;
    #1;
    chk("async_eth0", cnterr_eth0, 32'h0);
    chk("async_eth2", cnterr_eth2, 32'h0);
    chk("async_status", status_eth, 32'h0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_eth0", cnterr_eth0, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
